// File: rtl/activation_lut_loader.sv
// ---------------------------------------------------------------------------
// activation_lut_loader
//   Write side of the activation-function lookup table. It takes a stream of
//   2**ADDR_W signed samples over a valid/ready handshake and stores them in a
//   register table. It serves base/next_data pairs to the LUT+interpolator
//   stage, so activation curves can be loaded at run time.
//
//   Optional feature: define LUT_CHECKSUM_EN to add a running mod-2**DATA_W
//   sum of the loaded samples on the checksum port.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   load_start   pulse: begin or restart a table load
//   wr_valid     wr_data is valid this cycle
//   wr_ready     loader accepts wr_data (high for the whole LOAD state)
//   wr_data      sample, stored at the next free index
//   busy         high while loading
//   table_valid  every entry has been written since the last load_start
//   address      read index
//   base         entry[address], registered
//   next_data    entry[address+1], saturated to the top entry
//   checksum     (LUT_CHECKSUM_EN only) sum of the samples accepted so far
// ---------------------------------------------------------------------------
module activation_lut_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              table_valid,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next_data
`ifdef LUT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int              DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                wr_ready_q, wr_ready_d;
    logic                busy_q, busy_d;
    logic                table_valid_q, table_valid_d;
    logic [DATA_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   next_q, next_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                beat;
    logic                enter_load;
`ifdef LUT_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

    // wr_ready is only ever high in LOAD, so a beat implies the LOAD state.
    assign beat = wr_valid && wr_ready_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        wr_ready_d    = wr_ready_q;
        busy_d        = busy_q;
        table_valid_d = table_valid_q;
        mem_d         = mem_q;
        enter_load    = 1'b0;
`ifdef LUT_CHECKSUM_EN
        checksum_d    = checksum_q;
`endif
        // Reads come from the current table, so a same-cycle write to the
        // same entry is seen only on the following read.
        base_d = mem_q[address];
        next_d = (address == LAST) ? mem_q[LAST] : mem_q[address + ADDR_W'(1)];

        case (state_q)
            IDLE: if (load_start) enter_load = 1'b1;
            LOAD: begin
                // A restart outranks a beat in the same cycle; the beat is lost.
                if (load_start) begin
                    enter_load = 1'b1;
                end else if (beat) begin
                    mem_d[wr_ptr_q] = wr_data;
                    wr_ptr_d        = wr_ptr_q + ADDR_W'(1);  // wraps to 0 after LAST
`ifdef LUT_CHECKSUM_EN
                    checksum_d      = checksum_q + wr_data;
`endif
                    if (wr_ptr_q == LAST) begin
                        state_d       = DONE;
                        wr_ready_d    = 1'b0;
                        busy_d        = 1'b0;
                        table_valid_d = 1'b1;
                    end
                end
            end
            DONE:    if (load_start) enter_load = 1'b1;
            default: state_d = IDLE;
        endcase

        if (enter_load) begin
            state_d       = LOAD;
            wr_ptr_d      = '0;
            table_valid_d = 1'b0;
            busy_d        = 1'b1;
            wr_ready_d    = 1'b1;
`ifdef LUT_CHECKSUM_EN
            checksum_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            wr_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            table_valid_q <= 1'b0;
            base_q        <= '0;
            next_q        <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef LUT_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_ready_q    <= wr_ready_d;
            busy_q        <= busy_d;
            table_valid_q <= table_valid_d;
            base_q        <= base_d;
            next_q        <= next_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef LUT_CHECKSUM_EN
            checksum_q    <= checksum_d;
`endif
        end
    end

    assign wr_ready    = wr_ready_q;
    assign busy        = busy_q;
    assign table_valid = table_valid_q;
    assign base        = base_q;
    assign next_data   = next_q;
`ifdef LUT_CHECKSUM_EN
    assign checksum    = checksum_q;
`endif

endmodule

// File: tb/tb_activation_lut_loader.sv
module tb_activation_lut_loader;

    logic       clk = 1'b0;
    logic       rst, load_start, wr_valid, wr_ready, busy, table_valid;
    logic [7:0] wr_data, base, next_data;
    logic [3:0] address;
`ifdef LUT_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    activation_lut_loader #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .busy(busy), .table_valid(table_valid), .address(address),
        .base(base), .next_data(next_data)
`ifdef LUT_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the table contents and the loader's visible status.
    logic [7:0] m_mem [16];
    bit         m_loading;
    int         m_ptr;
    bit         m_tv;
    logic [7:0] m_cs;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp_base;
        logic [7:0] exp_next;
    } rd_vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model and compare.
    task automatic cyc(input logic r, input logic ls, input logic wv,
                       input logic [7:0] wd, input logic [3:0] a);
        logic [7:0] e_base, e_next;
        rst = r; load_start = ls; wr_valid = wv; wr_data = wd; address = a;
        e_base = m_mem[a];
        e_next = (a == 4'd15) ? m_mem[15] : m_mem[int'(a) + 1];
        @(posedge clk); #1;
        if (r) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_loading = 0; m_ptr = 0; m_tv = 0; m_cs = 8'h00;
            e_base = 8'h00; e_next = 8'h00;
        end else if (ls) begin
            m_loading = 1; m_ptr = 0; m_tv = 0; m_cs = 8'h00;
        end else if (wv && m_loading) begin
            m_mem[m_ptr] = wd;
            m_cs = m_cs + wd;
            if (m_ptr == 15) begin
                m_loading = 0; m_tv = 1; m_ptr = 0;
            end else begin
                m_ptr++;
            end
        end
        chk("base", base, e_base);
        chk("next_data", next_data, e_next);
        chk("wr_ready", wr_ready, m_loading);
        chk("busy", busy, m_loading);
        chk("table_valid", table_valid, m_tv);
`ifdef LUT_CHECKSUM_EN
        chk("checksum", checksum, m_cs);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 4'd0);
    endtask

    // Read an address and compare against a bench-supplied constant.
    task automatic rd(input string nm, input logic [3:0] a,
                      input logic [7:0] eb, input logic [7:0] en);
        cyc(0, 0, 0, 8'h00, a);
        chk({nm, ".base"}, base, eb);
        chk({nm, ".next"}, next_data, en);
    endtask

    initial begin
        rd_vec_t vec [5];
        vec[0] = '{4'd3,  8'd24,  8'd32};
        vec[1] = '{4'd15, 8'd120, 8'd120};
        vec[2] = '{4'd0,  8'd0,   8'd8};
        vec[3] = '{4'd7,  8'd56,  8'd64};
        vec[4] = '{4'd14, 8'd112, 8'd120};

        // 1. reset state
        cyc(1, 0, 0, 8'h00, 4'd0);
        cyc(1, 0, 0, 8'h00, 4'd0);
        rd("reset_rd9", 4'd9, 8'h00, 8'h00);
        chk("reset.table_valid", table_valid, 0);
        chk("reset.wr_ready", wr_ready, 0);

        // 2. back-to-back load of i*8
        cyc(0, 1, 0, 8'h00, 4'd0);
        chk("start.busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 8'(i * 8), 4'd0);
            chk("b2b.tv", table_valid, (i == 15) ? 1 : 0);
        end
        foreach (vec[k]) rd($sformatf("vec%0d", k), vec[k].addr, vec[k].exp_base, vec[k].exp_next);

        // 5. wr_valid in DONE is ignored
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h55, 4'(i));
        rd("done_ign", 4'd2, 8'd16, 8'd24);
        chk("done_ign.tv", table_valid, 1);

        // 3. gapped load, samples 200-3*i
        cyc(0, 1, 0, 8'h00, 4'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 8'(200 - 3 * i), 4'd0);
            chk("gap.busy", busy, (i == 15) ? 0 : 1);
            if (i != 15) cyc(0, 0, 0, 8'h55, 4'd0);
        end
        for (int i = 0; i < 15; i++)
            rd("gap_rd", 4'(i), 8'(200 - 3 * i), 8'(200 - 3 * (i + 1)));

        // 4. restart with a coincident beat, then full 0x7F load
        cyc(0, 1, 0, 8'h00, 4'd0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'(i + 1), 4'd0);
        cyc(0, 1, 1, 8'hAA, 4'd0);
        chk("restart.busy", busy, 1);
        chk("restart.tv", table_valid, 0);
        rd("restart_keep", 4'd7, 8'(200 - 21), 8'(200 - 24));
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 8'h7F, 4'd0);
        chk("7f.tv", table_valid, 1);
        for (int i = 0; i < 16; i++) rd("7f_rd", 4'(i), 8'h7F, 8'h7F);

        // 6. checksum load, then reset mid-load
        cyc(0, 1, 0, 8'h00, 4'd0);
        cyc(0, 0, 1, 8'hF0, 4'd0);
        cyc(0, 0, 1, 8'h20, 4'd0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 1, 8'h00, 4'd0);
        chk("cs.tv", table_valid, 1);
`ifdef LUT_CHECKSUM_EN
        chk("cs.value", checksum, 8'h10);
        idle(2);
        chk("cs.stable", checksum, 8'h10);
`endif
        cyc(0, 1, 0, 8'h00, 4'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h33, 4'd0);
        cyc(1, 0, 0, 8'h00, 4'd0);
        chk("midrst.tv", table_valid, 0);
        chk("midrst.busy", busy, 0);
`ifdef LUT_CHECKSUM_EN
        chk("midrst.cs", checksum, 0);
`endif
        rd("midrst_rd", 4'd0, 8'h00, 8'h00);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++)
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
